// File: rtl/prog_feeder.sv
// Program sequencer feeding DIN/Run of the 9-bit processor from a loadable program memory.
module prog_feeder #(
  parameter int W       = 9,
  parameter int AW      = 5,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [W-1:0]  LoadData,
  input  logic          Done,
  output logic [W-1:0]  DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Halted,
  output logic          Err,
  output logic [7:0]    InstrCount
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   mem [DEPTH];
  logic [W-1:0]   fetch_word;
  logic [W-1:0]   din_n;
  logic           run_n;
  logic [AW-1:0]  pc_n, pc_inc;
  logic           halted_n, err_n;
  logic [7:0]     cnt_n;
  logic [TW-1:0]  tcnt, tcnt_n;
  logic           load_ok;

  assign fetch_word = mem[PC];
  assign load_ok    = (state == S_IDLE) || (state == S_HALT) || (state == S_ERROR);

  always_ff @(posedge Clock) begin
    if (LoadEn && load_ok) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      DIN        <= '0;
      Run        <= 1'b0;
      PC         <= '0;
      Halted     <= 1'b0;
      Err        <= 1'b0;
      InstrCount <= '0;
      tcnt       <= '0;
    end else begin
      state      <= state_n;
      DIN        <= din_n;
      Run        <= run_n;
      PC         <= pc_n;
      Halted     <= halted_n;
      Err        <= err_n;
      InstrCount <= cnt_n;
      tcnt       <= tcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    din_n    = DIN;
    run_n    = Run;
    pc_n     = PC;
    halted_n = Halted;
    err_n    = Err;
    cnt_n    = InstrCount;
    tcnt_n   = tcnt;
    pc_inc   = PC + 1'b1;
    case (state)
      S_IDLE, S_HALT, S_ERROR: begin
        run_n = 1'b0;
        if (Start) begin
          pc_n     = '0;
          cnt_n    = '0;
          err_n    = 1'b0;
          halted_n = 1'b0;
          state_n  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_word[2:0] == OP_HALT) begin
          halted_n = 1'b1;
          state_n  = S_HALT;
        end else begin
          din_n   = fetch_word;
          run_n   = 1'b1;
          pc_n    = pc_inc;
          if (InstrCount != '1) begin
            cnt_n = InstrCount + 8'd1;
          end
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        run_n  = 1'b0;
        tcnt_n = '0;
        // DIN still holds the issued instruction here, so its opcode decides the immediate fetch
        if (DIN[2:0] == OP_MVI) begin
          din_n = fetch_word;
          pc_n  = pc_inc;
        end
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (Done) begin
          state_n = S_FETCH;
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (tcnt == TW'(TIMEOUT - 1)) begin
            err_n   = 1'b1;
            run_n   = 1'b0;
            state_n = S_ERROR;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/prog_feeder.md
Name: prog_feeder

Overview:
Program sequencer that sits directly upstream of the 9-bit processor and drives its DIN and Run inputs from a small loadable program memory. It issues one instruction word per processor cycle and, for mvi, supplies the immediate word as the following DIN value. It then waits for the processor's Done before fetching the next word. The host loads the program through a write port while the feeder is idle, then pulses Start.

Parameters:
W, 9, instruction/data word width (matches processor DIN)
AW, 5, program memory address width
DEPTH, 32, program memory words (2**AW)
TIMEOUT, 15, max cycles to wait for Done before flagging error

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  one-cycle pulse: begin execution at address 0
LoadEn  input  1  write enable for program memory
LoadAddr  input  AW  program memory write address
LoadData  input  W  program memory write data
Done  input  1  processor Done (combinational from processor, sampled on Clock)
DIN  output  W  word presented to processor DIN (registered)
Run  output  1  processor Run (registered)
PC  output  AW  address of next word to fetch
Halted  output  1  high while in HALT state
Err  output  1  high while in ERROR state (Done timeout)
InstrCount  output  8  instructions issued since Start, saturating at 255

Behaviour:
- Reset (async, any state): state=IDLE, DIN=0, Run=0, PC=0, Halted=0, Err=0, InstrCount=0, timeout counter=0. Memory contents are not cleared.
- Opcode = word[2:0]. 000 mv, 001 mvi, 010 add, 011 sub, 111 HALT (never issued to the processor). All other opcodes are issued like mv (one word).
- Memory writes: mem[LoadAddr]<=LoadData on the edge where LoadEn=1, accepted only in IDLE, HALT or ERROR; ignored otherwise. Read is combinational from the array.
- States: IDLE, FETCH, ISSUE, WAIT, HALT, ERROR.
- IDLE: Run=0. Start=1 -> PC<=0, InstrCount<=0, Err<=0, go to FETCH. If Start and LoadEn occur together, the write completes and the new word is visible at fetch.
- FETCH: if mem[PC] opcode is 111 -> go to HALT, Halted<=1, PC unchanged. Otherwise on the same edge DIN<=mem[PC], Run<=1, PC<=PC+1 (mod DEPTH), InstrCount<=sat+1, go to ISSUE.
- ISSUE (one cycle, processor in T0, latches IR): on exit Run<=0 and timeout counter<=0.
  - If the opcode is mvi: DIN<=mem[PC], PC<=PC+1, so the immediate is on DIN during processor T1.
  - Otherwise DIN holds its value.
  - Go to WAIT.
- WAIT: Done=1 sampled -> go to FETCH (next Run issues two cycles after Done). Otherwise the counter increments; when it reaches TIMEOUT with Done still 0 -> go to ERROR, Err<=1, Run=0.
- Minimum cadence for mv/mvi: FETCH, ISSUE, WAIT = 3 cycles per instruction.
- HALT / ERROR: outputs hold, Run=0. Start -> same as from IDLE (restart at 0, clears Halted/Err).
- Start in any other state is ignored.
- PC wraps DEPTH-1 -> 0, including an mvi immediate fetched across the wrap.
- Reset mid-instruction forces Run=0 immediately (async); the processor must be reset concurrently.

Test Plan:
- Load mem[0]=9'o010 (mv R1,R0 form, opcode 000), mem[1]=9'o007 (HALT), Start -> Run high exactly 1 cycle with DIN=mem[0]; with Done returned in the cycle after ISSUE, Halted=1 and InstrCount=1, PC=1.
- Load mvi R2 at mem[0] with immediate 9'h05A at mem[1], HALT at mem[2] -> DIN=mvi word while Run=1, DIN=9'h05A the next cycle, InstrCount=1, PC=2 at halt.
- Hold Done=0 after ISSUE -> Err=1 exactly TIMEOUT cycles after entering WAIT, Run stays 0. A subsequent Start clears Err and restarts at PC=0.
- LoadEn pulses during WAIT targeting mem[5] -> mem[5] unchanged (read back via a later fetch). The same write while HALT -> takes effect.
- Program of 31 mv words at mem[0..30], mvi at mem[31] with immediate at mem[0] -> PC wraps and the immediate equals mem[0].
- Assert Reset while Run=1 -> Run=0, DIN=0, PC=0 within the same cycle (async). After release, the block remains IDLE until Start.
